// File: rtl/compare_update_scheduler_if.sv
// compare_update_scheduler_if
//   Bundles the two requester handshakes (modulator stream, host bus) and the
//   compare-unit shadow-write port of the compare update scheduler.
//
//   Signals:
//     mod_valid/mod_ready/mod_data/mod_last   modulator beat handshake
//     host_valid/host_ready/host_address/host_data  host single-write handshake
//     cu_we/cu_address/cu_data                compare-unit shadow write
//
//   Modports:
//     master  requester / compare-unit side (drives requests, observes writes)
//     slave   the scheduler itself
interface compare_update_scheduler_if #(
  parameter int COUNTER_WIDTH = 16
);
  logic                     mod_valid;
  logic                     mod_ready;
  logic [COUNTER_WIDTH-1:0] mod_data;
  logic                     mod_last;

  logic                     host_valid;
  logic                     host_ready;
  logic [2:0]               host_address;
  logic [COUNTER_WIDTH-1:0] host_data;

  logic                     cu_we;
  logic [2:0]               cu_address;
  logic [COUNTER_WIDTH-1:0] cu_data;

  modport master (
    output mod_valid, mod_data, mod_last,
    output host_valid, host_address, host_data,
    input  mod_ready, host_ready,
    input  cu_we, cu_address, cu_data
  );

  modport slave (
    input  mod_valid, mod_data, mod_last,
    input  host_valid, host_address, host_data,
    output mod_ready, host_ready,
    output cu_we, cu_address, cu_data
  );
endinterface

// File: rtl/compare_update_scheduler.sv
// compare_update_scheduler
//   Arbitrates compare-threshold updates from the modulator (6-beat sets) and
//   the host bus (single writes) onto the compare unit's shadow-write port,
//   and issues the period-aligned reload strobe once a complete set sits in
//   the shadow registers.
//
//   Ports:
//     clock            system clock
//     reset            synchronous, active-low
//     counter_stopped  carrier counter halted (no reloads, no pending sets)
//     period_event     one-cycle pulse at the carrier period boundary
//     flags_clear      clears the sticky overrun / protocol_error flags
//     bus              requester handshakes and compare-unit write port
//     reload_compare   one-cycle working-register reload strobe
//     set_pending      complete set in shadow, awaiting reload
//     overrun          sticky: a set completed while another was pending
//     protocol_error   sticky: mod_last position mismatch
module compare_update_scheduler #(
  parameter int COUNTER_WIDTH = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         counter_stopped,
  input  logic                         period_event,
  input  logic                         flags_clear,
  compare_update_scheduler_if.slave    bus,
  output logic                         reload_compare,
  output logic                         set_pending,
  output logic                         overrun,
  output logic                         protocol_error
);

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    MOD_BURST = 1'b1
  } state_t;

  localparam logic [2:0] LAST_BEAT = 3'd5;

  state_t                   state_q, state_d;
  logic [2:0]               beat_q, beat_d;
  logic                     last_host_q, last_host_d;
  logic                     mod_ready_c, host_ready_c;
  logic                     mod_fire, host_fire;
  logic                     set_done, set_abort;
  logic                     set_done_q;
  logic                     cu_we_q;
  logic [2:0]               cu_address_q;
  logic [COUNTER_WIDTH-1:0] cu_data_q;

  // Ready depends only on state, the valids and the last winner. A modulator
  // set in progress owns the port; in IDLE a tie goes to whoever lost last.
  // Both readies are held low while reset is asserted.
  always_comb begin
    mod_ready_c  = 1'b0;
    host_ready_c = 1'b0;
    if (reset) begin
      case (state_q)
        IDLE: begin
          mod_ready_c  = bus.mod_valid && (!bus.host_valid || last_host_q);
          host_ready_c = bus.host_valid && !(bus.mod_valid && last_host_q);
        end
        MOD_BURST: begin
          mod_ready_c = 1'b1;
        end
        default: begin
          mod_ready_c  = 1'b0;
          host_ready_c = 1'b0;
        end
      endcase
    end
  end

  assign mod_fire  = bus.mod_valid && mod_ready_c;
  assign host_fire = bus.host_valid && host_ready_c;

  // Beat sequencing: a beat carrying mod_last before beat 5, or beat 5
  // without mod_last, aborts the set. Aborted beats are still written.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    last_host_d = last_host_q;
    set_done    = 1'b0;
    set_abort   = 1'b0;
    if (mod_fire) begin
      last_host_d = 1'b0;
      if (beat_q == LAST_BEAT) begin
        beat_d  = 3'd0;
        state_d = IDLE;
        if (bus.mod_last) begin
          set_done = 1'b1;
        end else begin
          set_abort = 1'b1;
        end
      end else if (bus.mod_last) begin
        beat_d    = 3'd0;
        state_d   = IDLE;
        set_abort = 1'b1;
      end else begin
        beat_d  = beat_q + 3'd1;
        state_d = MOD_BURST;
      end
    end else if (host_fire) begin
      last_host_d = 1'b1;
    end
  end

  // set_done is delayed one cycle so set_pending only rises once the final
  // shadow write has actually been presented to the compare unit.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= IDLE;
      beat_q         <= 3'd0;
      last_host_q    <= 1'b1;
      cu_we_q        <= 1'b0;
      cu_address_q   <= 3'd0;
      cu_data_q      <= '0;
      set_done_q     <= 1'b0;
      reload_compare <= 1'b0;
      set_pending    <= 1'b0;
      overrun        <= 1'b0;
      protocol_error <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      last_host_q <= last_host_d;
      cu_we_q     <= mod_fire || host_fire;
      if (mod_fire) begin
        cu_address_q <= beat_q;
        cu_data_q    <= bus.mod_data;
      end else if (host_fire) begin
        cu_address_q <= bus.host_address;
        cu_data_q    <= bus.host_data;
      end
      set_done_q     <= set_done;
      reload_compare <= set_pending && period_event && !counter_stopped;

      // A period_event seen while set_pending is still low is ignored, so a
      // set completing in the same cycle waits for the next boundary.
      if (counter_stopped) begin
        set_pending <= 1'b0;
      end else if (set_pending && period_event) begin
        set_pending <= 1'b0;
      end else if (set_done_q) begin
        set_pending <= 1'b1;
      end

      // Error events take priority over a simultaneous flags_clear.
      if (set_done_q && set_pending && !counter_stopped) begin
        overrun <= 1'b1;
      end else if (flags_clear) begin
        overrun <= 1'b0;
      end

      if (set_abort) begin
        protocol_error <= 1'b1;
      end else if (flags_clear) begin
        protocol_error <= 1'b0;
      end
    end
  end

  assign bus.mod_ready  = mod_ready_c;
  assign bus.host_ready = host_ready_c;
  assign bus.cu_we      = cu_we_q;
  assign bus.cu_address = cu_address_q;
  assign bus.cu_data    = cu_data_q;

endmodule

// File: tb/tb_compare_update_scheduler.sv
// tb_compare_update_scheduler
//   Self-checking bench for compare_update_scheduler: a table of per-cycle
//   vectors for the first modulator set and the arbitration ties, followed by
//   hand-written sequences for overrun, stopped counter, protocol errors and
//   mid-set reset.
module tb_compare_update_scheduler;

  localparam int W = 16;

  logic clock           = 1'b0;
  logic reset           = 1'b0;
  logic counter_stopped = 1'b0;
  logic period_event    = 1'b0;
  logic flags_clear     = 1'b0;
  logic reload_compare;
  logic set_pending;
  logic overrun;
  logic protocol_error;

  int checks   = 0;
  int failures = 0;

  compare_update_scheduler_if #(.COUNTER_WIDTH(W)) bus ();

  compare_update_scheduler #(.COUNTER_WIDTH(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .counter_stopped(counter_stopped),
    .period_event   (period_event),
    .flags_clear    (flags_clear),
    .bus            (bus),
    .reload_compare (reload_compare),
    .set_pending    (set_pending),
    .overrun        (overrun),
    .protocol_error (protocol_error)
  );

  always #5 clock = ~clock;

  // One record per cycle: inputs driven after a rising edge, readies checked
  // in that cycle, registered outputs checked just after the next edge.
  typedef struct {
    logic           mod_valid;
    logic [W-1:0]   mod_data;
    logic           mod_last;
    logic           host_valid;
    logic [2:0]     host_address;
    logic [W-1:0]   host_data;
    logic           period_event;
    logic           exp_mod_ready;
    logic           exp_host_ready;
    logic           exp_cu_we;
    logic [2:0]     exp_cu_address;
    logic [W-1:0]   exp_cu_data;
    logic           exp_set_pending;
    logic           exp_reload;
  } vec_t;

  vec_t vecs[10];

  task automatic expectValue(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    bus.mod_valid     = v.mod_valid;
    bus.mod_data      = v.mod_data;
    bus.mod_last      = v.mod_last;
    bus.host_valid    = v.host_valid;
    bus.host_address  = v.host_address;
    bus.host_data     = v.host_data;
    period_event      = v.period_event;
    #1;
    expectValue($sformatf("v%0d mod_ready", idx), bus.mod_ready, v.exp_mod_ready);
    expectValue($sformatf("v%0d host_ready", idx), bus.host_ready, v.exp_host_ready);
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    expectValue($sformatf("v%0d cu_we", idx), bus.cu_we, v.exp_cu_we);
    if (v.exp_cu_we) begin
      expectValue($sformatf("v%0d cu_address", idx), bus.cu_address, v.exp_cu_address);
      expectValue($sformatf("v%0d cu_data", idx), bus.cu_data, v.exp_cu_data);
    end
    expectValue($sformatf("v%0d set_pending", idx), set_pending, v.exp_set_pending);
    expectValue($sformatf("v%0d reload_compare", idx), reload_compare, v.exp_reload);
  endtask

  // Drives nbeats modulator beats (mod_last on beat last_idx, -1 for none)
  // and checks each shadow write one cycle after its handshake.
  task automatic sendSet(input int base, input int nbeats, input int last_idx,
                         input string tag);
    int waited;
    for (int i = 0; i < nbeats; i++) begin
      bus.mod_valid = 1'b1;
      bus.mod_data  = W'(base + i);
      bus.mod_last  = (i == last_idx);
      #1;
      waited = 0;
      while (!bus.mod_ready && waited < 20) begin
        @(posedge clock);
        #1;
        waited++;
      end
      if (!bus.mod_ready) begin
        expectValue($sformatf("%s beat%0d ready timeout", tag, i), 32'd0, 32'd1);
        bus.mod_valid = 1'b0;
        bus.mod_last  = 1'b0;
        return;
      end
      tick();
      expectValue($sformatf("%s beat%0d cu_we", tag, i), bus.cu_we, 1);
      expectValue($sformatf("%s beat%0d cu_address", tag, i), bus.cu_address, i);
      expectValue($sformatf("%s beat%0d cu_data", tag, i), bus.cu_data, base + i);
    end
    bus.mod_valid = 1'b0;
    bus.mod_last  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // mv, md, ml, hv, ha, hd, pe, emr, ehr, ewe, ea, ed, epend, ereload
    vecs[0] = '{1'b1, 16'd100, 1'b0, 1'b1, 3'd6, 16'h200, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 16'd100, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 16'd101, 1'b0, 1'b1, 3'd6, 16'h200, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 16'd101, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 16'd102, 1'b0, 1'b1, 3'd6, 16'h200, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 16'd102, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 16'd103, 1'b0, 1'b1, 3'd6, 16'h200, 1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 16'd103, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 16'd104, 1'b0, 1'b1, 3'd6, 16'h200, 1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 16'd104, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 16'd105, 1'b1, 1'b1, 3'd6, 16'h200, 1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 16'd105, 1'b0, 1'b0};
    // Tie right after the set: host wins; period_event as pending is set is ignored.
    vecs[6] = '{1'b1, 16'd106, 1'b0, 1'b1, 3'd6, 16'h200, 1'b1, 1'b0, 1'b1, 1'b1, 3'd6, 16'h200, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 16'd0,   1'b0, 1'b0, 3'd0, 16'h000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0,   1'b1, 1'b0};
    vecs[8] = '{1'b0, 16'd0,   1'b0, 1'b0, 3'd0, 16'h000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0,   1'b0, 1'b1};
    vecs[9] = '{1'b0, 16'd0,   1'b0, 1'b0, 3'd0, 16'h000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0,   1'b0, 1'b0};

    bus.mod_valid    = 1'b1;
    bus.mod_data     = '0;
    bus.mod_last     = 1'b0;
    bus.host_valid   = 1'b0;
    bus.host_address = '0;
    bus.host_data    = '0;

    // Reset state, with a valid modulator beat offered during reset.
    tick();
    tick();
    expectValue("reset mod_ready", bus.mod_ready, 0);
    expectValue("reset cu_we", bus.cu_we, 0);
    expectValue("reset set_pending", set_pending, 0);
    expectValue("reset reload_compare", reload_compare, 0);
    expectValue("reset overrun", overrun, 0);
    expectValue("reset protocol_error", protocol_error, 0);
    bus.mod_valid = 1'b0;
    reset = 1'b1;

    $display("[TB] table: first set, tie arbitration, reload");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(i, vecs[i]);
      tick();
      checkOutput(i, vecs[i]);
    end

    $display("[TB] overrun: two sets without a period boundary");
    sendSet(300, 6, 5, "B1");
    tick();
    expectValue("B1 set_pending", set_pending, 1);
    expectValue("B1 overrun", overrun, 0);
    sendSet(400, 6, 5, "B2");
    tick();
    expectValue("B2 overrun", overrun, 1);
    expectValue("B2 set_pending", set_pending, 1);
    period_event = 1'b1;
    tick();
    period_event = 1'b0;
    expectValue("B reload", reload_compare, 1);
    expectValue("B pending cleared", set_pending, 0);
    period_event = 1'b1;
    tick();
    period_event = 1'b0;
    expectValue("B single reload", reload_compare, 0);
    flags_clear = 1'b1;
    tick();
    flags_clear = 1'b0;
    expectValue("B overrun cleared", overrun, 0);

    $display("[TB] counter stopped");
    counter_stopped = 1'b1;
    sendSet(500, 6, 5, "C");
    tick();
    tick();
    expectValue("C set_pending", set_pending, 0);
    period_event = 1'b1;
    tick();
    period_event = 1'b0;
    expectValue("C reload", reload_compare, 0);
    tick();
    expectValue("C reload late", reload_compare, 0);
    counter_stopped = 1'b0;

    $display("[TB] protocol errors");
    sendSet(600, 4, 3, "D1");
    expectValue("D1 protocol_error", protocol_error, 1);
    tick();
    tick();
    expectValue("D1 set_pending", set_pending, 0);
    sendSet(700, 6, 5, "D2");
    tick();
    expectValue("D2 set_pending", set_pending, 1);
    period_event = 1'b1;
    tick();
    period_event = 1'b0;
    expectValue("D2 reload", reload_compare, 1);
    flags_clear = 1'b1;
    tick();
    expectValue("D protocol_error cleared", protocol_error, 0);
    // flags_clear held through a set missing its final marker: error wins.
    sendSet(800, 6, -1, "D3");
    flags_clear = 1'b0;
    expectValue("D3 protocol_error", protocol_error, 1);
    tick();
    tick();
    expectValue("D3 set_pending", set_pending, 0);

    $display("[TB] reset in the middle of a set");
    sendSet(850, 6, 5, "E0");
    tick();
    expectValue("E0 set_pending", set_pending, 1);
    sendSet(900, 3, -1, "E1");
    reset = 1'b0;
    tick();
    expectValue("E reset cu_we", bus.cu_we, 0);
    expectValue("E reset cu_address", bus.cu_address, 0);
    expectValue("E reset cu_data", bus.cu_data, 0);
    expectValue("E reset set_pending", set_pending, 0);
    expectValue("E reset reload", reload_compare, 0);
    expectValue("E reset overrun", overrun, 0);
    expectValue("E reset protocol_error", protocol_error, 0);
    expectValue("E reset mod_ready", bus.mod_ready, 0);
    expectValue("E reset host_ready", bus.host_ready, 0);
    reset = 1'b1;
    tick();
    expectValue("E no stale pending", set_pending, 0);
    sendSet(950, 6, 5, "E2");
    tick();
    expectValue("E2 set_pending", set_pending, 1);
    expectValue("E2 protocol_error", protocol_error, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/compare_update_scheduler.md
Name: compare_update_scheduler

Overview:
- Sequences compare-threshold updates from two requesters into the PWM compare unit's shadow-write interface. The requesters are a modulator stream delivering complete 6-value sets and a host bus issuing single writes.
- Issues the period-aligned reload strobe, so working thresholds change only at a carrier boundary and only after a complete set is written.
- Sits between the modulator/AXI register bank and the compare unit inside the PWM generator.

Parameters:
- COUNTER_WIDTH, 16, width of compare values and data paths.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low.
- counter_stopped  in  1  carrier counter halted; the compare unit writes working registers directly.
- period_event  in  1  single-cycle pulse at the carrier period boundary.
- mod_valid  in  1  modulator beat valid.
- mod_ready  out  1  modulator beat accepted when high with mod_valid.
- mod_data  in  COUNTER_WIDTH  modulator compare value.
- mod_last  in  1  marks the final (6th) beat of a set.
- host_valid  in  1  host write request.
- host_ready  out  1  host write accepted when high with host_valid.
- host_address  in  3  compare-unit address (0-5 single, 6/7 group).
- host_data  in  COUNTER_WIDTH  host write value.
- cu_we  out  1  compare-unit write enable.
- cu_address  out  3  compare-unit address.
- cu_data  out  COUNTER_WIDTH  compare-unit write data.
- reload_compare  out  1  single-cycle working-register reload strobe.
- set_pending  out  1  complete set written, awaiting reload.
- overrun  out  1  sticky: a set completed while the previous one was still pending.
- protocol_error  out  1  sticky: mod_last position mismatch.
- flags_clear  in  1  clears overrun and protocol_error.

Behaviour:
- Reset (reset low at a clock edge): all outputs are 0 and the beat counter is 0. The arbiter's last-winner is set to host, so the modulator wins the first tie. Any in-flight set is discarded.
- One compare-unit write is issued per cycle at most. For a handshake in cycle t, cu_we/cu_address/cu_data are registered and presented in cycle t+1. cu_we is high for exactly one cycle per handshake.
- Modulator set: 6 beats, mapped to cu_address 0..5 by an internal 3-bit beat counter. After the first beat is accepted, the set holds the lock (MOD_BURST state) and host_ready is forced to 0 until beat 5 is accepted or the set is aborted. mod_ready is 1 in MOD_BURST.
- Arbitration FSM:
  - IDLE: if only one requester is valid, it is granted.
  - IDLE: if both are valid, the requester that did not win last is granted (round-robin).
  - IDLE: a granted modulator beat moves the FSM to MOD_BURST; a host grant stays in IDLE.
  - MOD_BURST: return to IDLE after beat 5 is accepted, or on a protocol abort.
- ready signals are combinational from state and the valid inputs. No combinational path runs from ready back to valid.
- mod_last rules:
  - mod_last high on beats 0-4: early abort. Set protocol_error, discard the set (no pending), clear the beat counter, return to IDLE. The beats already written stay in shadow.
  - mod_last low on beat 5: treat as a missing marker. Set protocol_error, discard the set, clear the beat counter.
- Pending/reload:
  - set_pending rises in the cycle after cu_we for beat 5 of a valid set, i.e. once the shadow holds the full set.
  - If set_pending is high and period_event is high and counter_stopped is 0, reload_compare pulses in the next cycle and set_pending clears in that same cycle.
  - If period_event arrives in the same cycle that set_pending is being set, it is not used; the reload waits for the next period_event.
  - If a new set completes while set_pending is 1, set overrun. set_pending stays 1, and a single reload covers the newest values.
  - While counter_stopped is 1: reload_compare is never asserted, a completing set does not set set_pending, and any existing set_pending clears.
- Host writes never set set_pending and never trigger a reload.
- flags_clear clears overrun and protocol_error in the next cycle. If an error event and flags_clear occur in the same cycle, the flag is set.

Test Plan:
- Counter running; modulator set 100..105 back-to-back with mod_last on beat 5 -> cu writes (0,100)..(5,105) in 6 consecutive cycles. set_pending=1 one cycle after the last write. After a later period_event: exactly one reload_compare pulse in the following cycle, set_pending=0.
- host_valid(addr 6, data 0x200) and mod_valid asserted together after reset -> modulator wins, host_ready=0 for the whole set, then host write (6,0x200) issued. In the next tie, host wins.
- Two complete sets with no period_event between them -> overrun=1 after the second set. One period_event then yields a single reload_compare. flags_clear -> overrun=0.
- counter_stopped=1; full set written -> 6 cu writes, set_pending stays 0. period_event gives no reload_compare.
- mod_last on beat 3 -> protocol_error=1, set_pending=0. The next 6-beat set starts at address 0 and reloads normally.
- reset low after beat 2 accepted -> all outputs 0. The next set starts at cu_address 0 and no stale pending remains.
